// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a 32-bit word stream into 512-bit blocks,
// appends the 0x80 marker, zero fill and bit length, and sequences sha256_core.
module sha256_msg_padder #(
   parameter int unsigned LEN_W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   input  logic [1:0]   s_nbytes,
   output logic         core_init,
   output logic         core_next,
   output logic [511:0] core_block,
   input  logic         core_ready,
   input  logic         core_digest_valid,
   output logic         busy,
   output logic         msg_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_ISSUE, S_WAIT0, S_WAIT, S_PADX, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [4:0]         idx_q, idx_d;
   logic [LEN_W-1:0]   bits_q, bits_d;
   logic               first_blk_q, first_blk_d;
   logic               pad_pend_q, pad_pend_d;
   logic [4:0]         pad_pos_q, pad_pos_d;
   logic               pad_mark_q, pad_mark_d;
   logic               pad_extra_q, pad_extra_d;
   logic               extra_mark_q, extra_mark_d;
   logic               final_q, final_d;
   logic [15:0][31:0]  blk_q, blk_d;

   logic               rdy;
   logic [4:0]         base_idx;
   logic [LEN_W-1:0]   base_bits;
   logic [2:0]         nbytes;
   logic [31:0]        last_word;
   logic [63:0]        len64;

   // Word 0 lives in the top 32 bits of the block.
   function automatic logic [3:0] wsel(input logic [4:0] i);
      return 4'(5'd15 - i);
   endfunction

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      bits_d       = bits_q;
      first_blk_d  = first_blk_q;
      pad_pend_d   = pad_pend_q;
      pad_pos_d    = pad_pos_q;
      pad_mark_d   = pad_mark_q;
      pad_extra_d  = pad_extra_q;
      extra_mark_d = extra_mark_q;
      final_d      = final_q;
      blk_d        = blk_q;
      rdy          = 1'b0;
      core_init    = 1'b0;
      core_next    = 1'b0;
      msg_done     = 1'b0;
      base_idx     = idx_q;
      base_bits    = bits_q;
      len64        = 64'(bits_q);
      nbytes       = (s_last && s_nbytes != 2'd0) ? {1'b0, s_nbytes} : 3'd4;

      case (s_nbytes)
         2'd1:    last_word = {s_data[31:24], 8'h80, 16'h0000};
         2'd2:    last_word = {s_data[31:16], 8'h80, 8'h00};
         2'd3:    last_word = {s_data[31:8], 8'h80};
         default: last_word = s_data;
      endcase

      case (state_q)
         S_IDLE: begin
            rdy         = 1'b1;
            base_idx    = '0;
            base_bits   = '0;
            final_d     = 1'b0;
            pad_extra_d = 1'b0;
            pad_pend_d  = 1'b0;
         end
         S_FILL: begin
            if (pad_pend_q) begin
               // Marker position p: words after p are cleared; p==16 defers the marker to the extra block.
               for (int unsigned i = 0; i < 16; i++) begin
                  if (i > 32'(pad_pos_q))
                     blk_d[4'(15 - i)] = '0;
                  else if (i == 32'(pad_pos_q) && pad_mark_q)
                     blk_d[4'(15 - i)] = 32'h8000_0000;
               end
               if (pad_pos_q <= 5'd13) begin
                  blk_d[1] = len64[63:32];
                  blk_d[0] = len64[31:0];
                  final_d  = 1'b1;
               end else begin
                  pad_extra_d  = 1'b1;
                  extra_mark_d = (pad_pos_q == 5'd16);
               end
               pad_pend_d = 1'b0;
               state_d    = S_ISSUE;
            end else begin
               rdy = (idx_q < 5'd16);
            end
         end
         S_ISSUE: begin
            core_init   = first_blk_q;
            core_next   = !first_blk_q;
            first_blk_d = 1'b0;
            state_d     = S_WAIT0;
         end
         S_WAIT0: state_d = S_WAIT;
         S_WAIT: begin
            if (core_ready) begin
               if (pad_extra_q)
                  state_d = S_PADX;
               else if (final_q)
                  state_d = S_DONE;
               else begin
                  idx_d   = '0;
                  state_d = S_FILL;
               end
            end
         end
         S_PADX: begin
            blk_d        = '0;
            blk_d[15]    = extra_mark_q ? 32'h8000_0000 : 32'h0;
            blk_d[1]     = len64[63:32];
            blk_d[0]     = len64[31:0];
            pad_extra_d  = 1'b0;
            extra_mark_d = 1'b0;
            final_d      = 1'b1;
            state_d      = S_ISSUE;
         end
         S_DONE: begin
            if (core_digest_valid) begin
               msg_done    = 1'b1;
               first_blk_d = 1'b1;
               final_d     = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      s_ready = rdy && !reset;

      if (s_valid && s_ready) begin
         blk_d[wsel(base_idx)] = s_last ? last_word : s_data;
         idx_d   = base_idx + 5'd1;
         bits_d  = base_bits + LEN_W'({nbytes, 3'b000});
         state_d = S_FILL;
         if (s_last) begin
            pad_pend_d = 1'b1;
            pad_mark_d = (s_nbytes == 2'd0);
            pad_pos_d  = (s_nbytes == 2'd0) ? base_idx + 5'd1 : base_idx;
         end else if (base_idx == 5'd15) begin
            state_d = S_ISSUE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         bits_q       <= '0;
         first_blk_q  <= 1'b1;
         pad_pend_q   <= 1'b0;
         pad_pos_q    <= '0;
         pad_mark_q   <= 1'b0;
         pad_extra_q  <= 1'b0;
         extra_mark_q <= 1'b0;
         final_q      <= 1'b0;
         blk_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         bits_q       <= bits_d;
         first_blk_q  <= first_blk_d;
         pad_pend_q   <= pad_pend_d;
         pad_pos_q    <= pad_pos_d;
         pad_mark_q   <= pad_mark_d;
         pad_extra_q  <= pad_extra_d;
         extra_mark_q <= extra_mark_d;
         final_q      <= final_d;
         blk_q        <= blk_d;
      end
   end

   assign core_block = blk_q;
   assign busy       = (state_q != S_IDLE);

endmodule
